// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a multiplexed 8-digit 7-segment scan.
// Synchronises an/duan/duan1, waits for each strobe to settle, decodes the segment
// pattern into the scroller's 5-bit character codes and reports complete frames.
// Optional feature macro: SEG_DP_CAPTURE_EN (capture decimal points into dp).
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  duan,
  input  logic [7:0]  duan1,
  output logic [39:0] chars,
  output logic [7:0]  valid,
  output logic [7:0]  dp,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        bad_seg,
  output logic        stale
);

  localparam int unsigned CW = 8;
  localparam int unsigned WW = 20;
`ifdef SEG_DP_CAPTURE_EN
  localparam int unsigned SEGW = 8;
`else
  localparam int unsigned SEGW = 7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_HELD
  } state_t;

  logic [7:0]    an_m_q, an_s_q;
  logic [7:0]    seg0_m_q, seg0_s_q;
  logic [7:0]    seg1_m_q, seg1_s_q;

  state_t        state_q;
  logic [CW-1:0] settle_cnt_q;
  logic [WW-1:0] wd_cnt_q;
  logic [7:0]    seen_q;
  logic [39:0]   chars_q;
  logic [7:0]    valid_q;
  logic          frame_done_q;
  logic [7:0]    frame_cnt_q;
  logic          bad_seg_q;
  logic          stale_q;

  logic [2:0]    idx_c;
  logic [5:0]    chars_lsb_c;
  logic          onehot_s_c, onehot_m_c;
  logic [7:0]    sel_s_c, sel_m_c;
  logic          an_chg_c, chg_c;
  logic          capture_c, stale_evt_c;
  logic [4:0]    code_c;
  logic [7:0]    seen_next_c;

  // Map an active-high a..g pattern to the scroller's character code.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F: seg_decode = 5'd0;
      7'h06: seg_decode = 5'd1;
      7'h5B: seg_decode = 5'd2;
      7'h4F: seg_decode = 5'd3;
      7'h66: seg_decode = 5'd4;
      7'h6D: seg_decode = 5'd5;
      7'h7D: seg_decode = 5'd6;
      7'h07: seg_decode = 5'd7;
      7'h7F: seg_decode = 5'd8;
      7'h6F: seg_decode = 5'd9;
      7'h76: seg_decode = 5'd10;  // H
      7'h79: seg_decode = 5'd11;  // E
      7'h3E: seg_decode = 5'd12;  // U
      7'h38: seg_decode = 5'd13;  // L
      7'h1E: seg_decode = 5'd14;  // J
      7'h6E: seg_decode = 5'd15;  // Y
      7'h00: seg_decode = 5'd16;  // blank
      default: seg_decode = 5'd31;
    endcase
  endfunction

  // Two-flop synchroniser on every pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_m_q   <= '0;
      an_s_q   <= '0;
      seg0_m_q <= '0;
      seg0_s_q <= '0;
      seg1_m_q <= '0;
      seg1_s_q <= '0;
    end else begin
      an_m_q   <= an;
      an_s_q   <= an_m_q;
      seg0_m_q <= duan;
      seg0_s_q <= seg0_m_q;
      seg1_m_q <= duan1;
      seg1_s_q <= seg1_m_q;
    end
  end

  // Digit select, change detection (incoming stage vs. synchronised stage) and capture decode.
  always_comb begin
    idx_c = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_s_q[i]) idx_c = 3'(i);
    end
    chars_lsb_c = 6'(idx_c) * 6'd5;
    onehot_s_c  = $onehot(an_s_q);
    onehot_m_c  = $onehot(an_m_q);
    sel_s_c     = idx_c[2] ? seg1_s_q : seg0_s_q;
    sel_m_c     = idx_c[2] ? seg1_m_q : seg0_m_q;
    an_chg_c    = (an_m_q != an_s_q);
    chg_c       = an_chg_c || (sel_m_c[SEGW-1:0] != sel_s_c[SEGW-1:0]);
    capture_c   = (state_q == ST_SETTLING) && !chg_c && (settle_cnt_q == 8'(SETTLE - 1));
    stale_evt_c = !an_chg_c && (wd_cnt_q == 20'(TIMEOUT - 1));
    code_c      = seg_decode(sel_s_c[6:0]);
    seen_next_c = seen_q | (8'b1 << idx_c);
  end

  // Settle FSM, capture/frame bookkeeping and anode watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      wd_cnt_q     <= '0;
      seen_q       <= '0;
      chars_q      <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      bad_seg_q    <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (an_chg_c) begin
        wd_cnt_q <= '0;
      end else if (wd_cnt_q != {WW{1'b1}}) begin
        wd_cnt_q <= wd_cnt_q + 20'd1;
      end

      if (chg_c) begin
        settle_cnt_q <= '0;
        state_q      <= onehot_m_c ? ST_SETTLING : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (onehot_s_c) begin
              state_q      <= ST_SETTLING;
              settle_cnt_q <= '0;
            end
          end
          ST_SETTLING: begin
            if (capture_c) state_q <= ST_HELD;
            else           settle_cnt_q <= settle_cnt_q + 8'd1;
          end
          ST_HELD: state_q <= ST_HELD;
          default: state_q <= ST_IDLE;
        endcase
      end

      // Capture takes priority over a simultaneous stale event.
      if (capture_c) begin
        chars_q[chars_lsb_c +: 5] <= code_c;
        valid_q[idx_c]            <= 1'b1;
        stale_q                   <= 1'b0;
        if (code_c == 5'd31) bad_seg_q <= 1'b1;
        if (seen_next_c == 8'hFF) begin
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 8'd1;
          seen_q       <= '0;
        end else begin
          seen_q <= seen_next_c;
        end
      end else if (stale_evt_c) begin
        stale_q <= 1'b1;
        valid_q <= '0;
        seen_q  <= '0;
      end
    end
  end

`ifdef SEG_DP_CAPTURE_EN
  logic [7:0] dp_q;

  // Decimal point of the captured digit.
  always_ff @(posedge clk) begin
    if (rst)            dp_q <= '0;
    else if (capture_c) dp_q[idx_c] <= sel_s_c[7];
  end

  assign dp = dp_q;
`else
  logic unused_dp_c;
  assign unused_dp_c = sel_s_c[7] ^ sel_m_c[7];
  assign dp = '0;
`endif

  assign chars      = chars_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign bad_seg    = bad_seg_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (SETTLE=16, TIMEOUT shortened to 2000).
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  an;
  logic [7:0]  duan;
  logic [7:0]  duan1;
  logic [39:0] chars;
  logic [7:0]  valid;
  logic [7:0]  dp;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        bad_seg;
  logic        stale;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;

`ifdef SEG_DP_CAPTURE_EN
  localparam logic [7:0] DP_EXP = 8'h04;
`else
  localparam logic [7:0] DP_EXP = 8'h00;
`endif

  localparam logic [39:0] CHARS_F1 = {5'd16, 5'd15, 5'd14, 5'd13, 5'd16, 5'd12, 5'd11, 5'd10};
  localparam logic [39:0] CHARS_F2 = {5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd1, 5'd0, 5'd2};
  localparam logic [39:0] CHARS_E3 = {5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd1, 5'd5, 5'd1};
  localparam logic [39:0] CHARS_DP = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

  seg_scan_decoder #(.SETTLE(16), .TIMEOUT(2000)) dut (
    .clk(clk), .rst(rst), .an(an), .duan(duan), .duan1(duan1),
    .chars(chars), .valid(valid), .dp(dp), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .bad_seg(bad_seg), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses away from the active edge.
  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_digit(input int d, input logic [7:0] pat);
    an = 8'b1 << d;
    if (d < 4) begin duan = pat;  duan1 = 8'h00; end
    else       begin duan = 8'h00; duan1 = pat;  end
  endtask

  function automatic logic [4:0] digit_of(input logic [39:0] c, input int d);
    logic [39:0] t;
    t = c >> (5 * d);
    return t[4:0];
  endfunction

  task automatic test_reset;
    rst = 1'b1; an = 8'h00; duan = 8'h00; duan1 = 8'h00;
    tick(3);
    rst = 1'b0;
    checks++; if (chars !== 40'd0) begin errors++; $display("FAIL reset_chars got=%h exp=0", chars); end
    checks++; if (valid !== 8'd0) begin errors++; $display("FAIL reset_valid got=%h exp=0", valid); end
    checks++; if (dp !== 8'd0) begin errors++; $display("FAIL reset_dp got=%h exp=0", dp); end
    checks++; if ({frame_done, frame_cnt, bad_seg, stale} !== 11'd0) begin
      errors++; $display("FAIL reset_flags got=%b/%h/%b/%b exp=0", frame_done, frame_cnt, bad_seg, stale);
    end
  endtask

  task automatic test_frames;
    logic [7:0] f1 [8];
    logic [7:0] f2 [8];
    int fd0;
    f1 = '{8'h76, 8'h79, 8'h3E, 8'h00, 8'h38, 8'h1E, 8'h6E, 8'h00};
    f2 = '{8'h5B, 8'h3F, 8'h06, 8'h6F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    fd0 = fd_count;
    for (int d = 0; d < 8; d++) begin set_digit(d, f1[d]); tick(100); end
    checks++; if (chars !== CHARS_F1) begin errors++; $display("FAIL frame1_chars got=%h exp=%h", chars, CHARS_F1); end
    checks++; if (fd_count - fd0 !== 1) begin errors++; $display("FAIL frame1_pulses got=%0d exp=1", fd_count - fd0); end
    checks++; if (valid !== 8'hFF) begin errors++; $display("FAIL frame1_valid got=%h exp=ff", valid); end
    for (int d = 0; d < 8; d++) begin set_digit(d, f2[d]); tick(100); end
    checks++; if (chars !== CHARS_F2) begin errors++; $display("FAIL frame2_chars got=%h exp=%h", chars, CHARS_F2); end
    checks++; if (fd_count - fd0 !== 2) begin errors++; $display("FAIL frame2_pulses got=%0d exp=2", fd_count - fd0); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL frame_cnt got=%0d exp=2", frame_cnt); end
    checks++; if (bad_seg !== 1'b0) begin errors++; $display("FAIL frames_bad_seg got=%b exp=0", bad_seg); end
  endtask

  task automatic test_latency;
    an = 8'h00; tick(20);
    set_digit(0, 8'h06);
    tick(17);
    checks++; if (digit_of(chars, 0) !== 5'd2) begin errors++; $display("FAIL latency_early got=%0d exp=2", digit_of(chars, 0)); end
    tick(1);
    checks++; if (digit_of(chars, 0) !== 5'd1) begin errors++; $display("FAIL latency_edge got=%0d exp=1", digit_of(chars, 0)); end
  endtask

  task automatic test_toggle;
    for (int i = 0; i < 7; i++) begin set_digit(1, (i % 2 == 0) ? 8'h4F : 8'h66); tick(10); end
    checks++; if (digit_of(chars, 1) !== 5'd0) begin errors++; $display("FAIL toggle_nocap got=%0d exp=0", digit_of(chars, 1)); end
    set_digit(1, 8'h6D);
    tick(16);
    checks++; if (digit_of(chars, 1) !== 5'd0) begin errors++; $display("FAIL toggle_early got=%0d exp=0", digit_of(chars, 1)); end
    tick(14);
    checks++; if (digit_of(chars, 1) !== 5'd5) begin errors++; $display("FAIL toggle_final got=%0d exp=5", digit_of(chars, 1)); end
  endtask

  task automatic test_multihot;
    int fd0;
    fd0 = fd_count;
    an = 8'b0000_0011; duan = 8'h7F; duan1 = 8'h00;
    tick(200);
    checks++; if (chars !== CHARS_E3) begin errors++; $display("FAIL multihot_chars got=%h exp=%h", chars, CHARS_E3); end
    checks++; if (valid !== 8'hFF) begin errors++; $display("FAIL multihot_valid got=%h exp=ff", valid); end
    checks++; if (fd_count != fd0) begin errors++; $display("FAIL multihot_frame got=%0d exp=%0d", fd_count, fd0); end
  endtask

  task automatic test_stale;
    set_digit(0, 8'h06);
    tick(1900);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_early got=%b exp=0", stale); end
    tick(200);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_set got=%b exp=1", stale); end
    checks++; if (valid !== 8'h00) begin errors++; $display("FAIL stale_valid got=%h exp=0", valid); end
    checks++; if (chars !== CHARS_E3) begin errors++; $display("FAIL stale_chars got=%h exp=%h", chars, CHARS_E3); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL stale_frame_cnt got=%0d exp=2", frame_cnt); end
    set_digit(4, 8'h07);
    tick(40);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear got=%b exp=0", stale); end
    checks++; if (valid !== 8'h10) begin errors++; $display("FAIL stale_revalid got=%h exp=10", valid); end
    checks++; if (digit_of(chars, 4) !== 5'd7) begin errors++; $display("FAIL stale_recap got=%0d exp=7", digit_of(chars, 4)); end
  endtask

  task automatic test_bad_seg_reset;
    set_digit(3, 8'h7F);
    tick(40);
    checks++; if (digit_of(chars, 3) !== 5'd8) begin errors++; $display("FAIL digit3_eight got=%0d exp=8", digit_of(chars, 3)); end
    checks++; if (bad_seg !== 1'b0) begin errors++; $display("FAIL bad_seg_early got=%b exp=0", bad_seg); end
    set_digit(5, 8'h49);
    tick(40);
    checks++; if (digit_of(chars, 5) !== 5'd31) begin errors++; $display("FAIL digit5_bad got=%0d exp=31", digit_of(chars, 5)); end
    checks++; if (bad_seg !== 1'b1) begin errors++; $display("FAIL bad_seg_set got=%b exp=1", bad_seg); end
    set_digit(6, 8'h3F);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if ({chars, valid, dp} !== 56'd0) begin errors++; $display("FAIL midrst_data got=%h/%h/%h exp=0", chars, valid, dp); end
    checks++; if ({frame_done, frame_cnt, bad_seg, stale} !== 11'd0) begin
      errors++; $display("FAIL midrst_flags got=%b/%h/%b/%b exp=0", frame_done, frame_cnt, bad_seg, stale);
    end
  endtask

  task automatic test_back_to_back_dp;
    logic [7:0] pats [8];
    int fd0;
    pats = '{8'h3F, 8'h06, 8'hDB, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    fd0 = fd_count;
    for (int d = 0; d < 8; d++) begin set_digit(d, pats[d]); tick(18); end
    tick(2);
    checks++; if (chars !== CHARS_DP) begin errors++; $display("FAIL b2b_chars got=%h exp=%h", chars, CHARS_DP); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL b2b_frame_cnt got=%0d exp=1", frame_cnt); end
    checks++; if (fd_count - fd0 !== 1) begin errors++; $display("FAIL b2b_pulses got=%0d exp=1", fd_count - fd0); end
    checks++; if (dp !== DP_EXP) begin errors++; $display("FAIL dp_bits got=%h exp=%h", dp, DP_EXP); end
  endtask

  task automatic test_short_strobe;
    an = 8'h00; tick(20);
    set_digit(0, 8'h6F);
    tick(10);
    an = 8'h00;
    tick(30);
    checks++; if (digit_of(chars, 0) !== 5'd0) begin errors++; $display("FAIL short_strobe got=%0d exp=0", digit_of(chars, 0)); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_latency();
    test_toggle();
    test_multihot();
    test_stale();
    test_bad_seg_reset();
    test_back_to_back_dp();
    test_short_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side decoder for the multiplexed 8-digit 7-segment interface (`an`, `duan`, `duan1`) that the scrolling-display top drives on the EGO1 board. It samples the anode strobe and both segment banks and rejects scan transitions and ghosting. It decodes each digit's segment pattern back into the same 5-bit character codes the scroll logic uses, and reports complete frames. It is used as an on-board loopback monitor and as a self-checking observer in display testbenches.

## Interface
Parameters:
- `SETTLE`, 16: consecutive identical samples required before a digit is captured (2..255).
- `TIMEOUT`, 400000: clocks without an anode change before the display is declared stale (≤ 2^20−1).

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous reset, active-high.
- `an` in 8: anode strobes, active-high, bit i = digit i.
- `duan` in 8: segments for digits 0–3, bit0=a … bit6=g, bit7=dp, active-high.
- `duan1` in 8: segments for digits 4–7, same bit order.
- `chars` out 40: decoded codes, `chars[5i+4:5i]` = digit i.
- `valid` out 8: bit i set once digit i has been captured since reset or stale.
- `dp` out 8: captured decimal points (see Configuration).
- `frame_done` out 1: one-clock pulse when all 8 digits have been captured.
- `frame_cnt` out 8: count of `frame_done` pulses, wraps 255→0.
- `bad_seg` out 1: sticky; set when an unrecognised pattern is captured.
- `stale` out 1: set when the anode has been static for `TIMEOUT` clocks.

## Operation
- Input stage: `an`, `duan`, `duan1` each pass through two flops (reset 0) to give `an_s`, `seg0_s`, `seg1_s`.
- Digit select: `an_s` one-hot gives index `idx`. A zero or multi-hot `an_s` forces state IDLE. Segment source is `seg0_s` for idx 0–3 and `seg1_s` for idx 4–7.
- State machine (reset → IDLE):
  - IDLE: `an_s` is not one-hot. When `an_s` becomes one-hot, go to SETTLING with `settle_cnt`=0.
  - SETTLING: each cycle with `{an_s, selected seg}` unchanged, `settle_cnt`++. Any change resets `settle_cnt` to 0 and the block stays in SETTLING, or goes to IDLE if `an_s` is no longer one-hot. When `settle_cnt` reaches `SETTLE`−1 on an unchanged cycle, the digit is captured and the state goes to HELD.
  - HELD: no further capture. Any change in `{an_s, seg}` returns to SETTLING (or IDLE), so each strobe captures at most once.
- Capture of digit `idx`:
  - `chars[idx]` ← decode(seg[6:0]). `valid[idx]` ← 1. Seen mask bit `idx` ← 1. `stale` ← 0.
- Decode table, codes in decimal: patterns for 0–9 → 0–9; H→10, E→11, U→12, L→13, J→14, Y→15; blank (0x00) → 16; any other pattern → 31 and `bad_seg` ← 1.
- Frame: if the seen mask becomes 8'hFF on a capture, `frame_done` pulses for that cycle, `frame_cnt`++ and the seen mask clears to 0. Recapturing an already-seen digit does not advance the frame.
- Watchdog: a 20-bit counter clears on any `an_s` change and otherwise increments, saturating. Reaching `TIMEOUT` sets `stale` ← 1 and clears `valid` and the seen mask. `chars` hold their last values. `frame_cnt` and `bad_seg` are kept.
- If a capture and a stale event occur in the same cycle, the capture wins and `stale` stays 0.

## Timing
- Reset values: `chars`=0, `valid`=0, `dp`=0, `frame_done`=0, `frame_cnt`=0, `bad_seg`=0, `stale`=0. All counters and the seen mask are 0 and the state is IDLE. `rst` asserted mid-operation clears everything on the next edge.
- Latency: once the pins have been stable from edge k, the capture registers update at edge k+1+SETTLE. With SETTLE=16 that is 17 clocks. The 2-flop sync accounts for 2 of those clocks.
- `frame_done` is asserted in the same cycle the final digit's `chars`/`valid` update becomes visible.
- Minimum strobe width for capture: SETTLE+2 clocks. Shorter strobes are ignored.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `SEG_DP_CAPTURE_EN` defined: bit7 of the selected segment bank participates in the stability compare, and `dp[idx]` ← seg[7] on capture.
- Not defined: bit7 is ignored in the stability compare and `dp` is tied to 0.

## Test plan
- Drive a static scan of "HEU LJY " then "20190000", each digit strobed for 100 clocks in order 0→7. Required: `chars` = {16,15,14,13,16,12,11,10} then the digit codes, one `frame_done` per frame, `frame_cnt`=2, `bad_seg`=0.
- Toggle the segment value every 10 clocks within a 100-clock strobe (SETTLE=16). Required: no capture until the final stable 17 clocks; the captured value is the last pattern.
- Drive `an`=8'b00000011 for 200 clocks. Required: state stays IDLE, `valid` unchanged, no `frame_done`.
- Hold `an`=8'h01 static for 400000 clocks after a full frame. Required: `stale`=1, `valid`=0, `chars` retained. The next strobe clears `stale` and sets only that `valid` bit.
- Strobe digit 3 with pattern 0x7F ("8") and digit 5 with 0x49 (unrecognised). Required: code 8 for digit 3; code 31 and `bad_seg`=1 for digit 5. Assert `rst` for 1 clock mid-strobe: all outputs return to 0.
- With `SEG_DP_CAPTURE_EN` defined, set bit7 on digit 2 only. Required: `dp`=8'h04. Without the macro: `dp`=0.
